// File: rtl/ddr_app_sequencer_if.sv
// rtl/ddr_app_sequencer_if.sv - request, write-data, read-return and MIG app_* signal bundle
interface ddr_app_sequencer_if #(
  parameter int ADDR_WIDTH      = 28,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_BURST_BEATS = 16
);
  localparam int LEN_WIDTH = (MAX_BURST_BEATS > 1) ? $clog2(MAX_BURST_BEATS) : 1;

  logic                    i_init_calib_complete;
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_rw;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [LEN_WIDTH-1:0]    i_req_len;
  logic [DATA_WIDTH-1:0]   i_wdata;
  logic [DATA_WIDTH/8-1:0] i_wmask;
  logic                    i_wdata_valid;
  logic                    o_wdata_ready;
  logic [DATA_WIDTH-1:0]   o_rd_data;
  logic                    o_rd_valid;
  logic                    o_done;
  logic                    o_busy;
  logic [ADDR_WIDTH-1:0]   o_app_addr;
  logic [2:0]              o_app_cmd;
  logic                    o_app_en;
  logic                    i_app_rdy;
  logic [DATA_WIDTH-1:0]   o_app_wdf_data;
  logic [DATA_WIDTH/8-1:0] o_app_wdf_mask;
  logic                    o_app_wdf_wren;
  logic                    o_app_wdf_end;
  logic                    i_app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   i_app_rd_data;
  logic                    i_app_rd_data_valid;

  // master = sequencer side, slave = MCU plus MIG side
  modport master (
    input  i_init_calib_complete, i_req_valid, i_req_rw, i_req_addr, i_req_len,
           i_wdata, i_wmask, i_wdata_valid, i_app_rdy, i_app_wdf_rdy,
           i_app_rd_data, i_app_rd_data_valid,
    output o_req_ready, o_wdata_ready, o_rd_data, o_rd_valid, o_done, o_busy,
           o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_mask,
           o_app_wdf_wren, o_app_wdf_end
  );

  modport slave (
    output i_init_calib_complete, i_req_valid, i_req_rw, i_req_addr, i_req_len,
           i_wdata, i_wmask, i_wdata_valid, i_app_rdy, i_app_wdf_rdy,
           i_app_rd_data, i_app_rd_data_valid,
    input  o_req_ready, o_wdata_ready, o_rd_data, o_rd_valid, o_done, o_busy,
           o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_mask,
           o_app_wdf_wren, o_app_wdf_end
  );
endinterface

// File: rtl/ddr_app_sequencer.sv
// rtl/ddr_app_sequencer.sv - splits MCU burst requests into per-beat MIG app_* commands
module ddr_app_sequencer #(
  parameter int ADDR_WIDTH      = 28,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_BURST_BEATS = 16,
  parameter int ADDR_STEP       = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic                 clk_166M66,
  input logic                 mcu_sys_rst,
  ddr_app_sequencer_if.master bus
);
  localparam int LEN_W = (MAX_BURST_BEATS > 1) ? $clog2(MAX_BURST_BEATS) : 1;
  localparam int CNT_W = LEN_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      beats_q, beats_d;
  logic [CNT_W-1:0]      cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;
  logic [OUT_W-1:0]      out_cnt_q, out_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic req_ready, cmd_pending, data_pending, app_en, cmd_fire;
  logic wren, wfire, rd_issue, rd_ret;

  always_comb begin
    // Holding off accepts during reset keeps o_req_ready low while the block is held
    req_ready    = (state_q == ST_IDLE) && bus.i_init_calib_complete && !mcu_sys_rst;
    cmd_pending  = cmd_cnt_q < beats_q;
    data_pending = data_cnt_q < beats_q;
    app_en       = cmd_pending && ((state_q == ST_WRITE) ||
                   ((state_q == ST_READ) && (out_cnt_q < OUT_W'(MAX_OUTSTANDING))));
    cmd_fire     = app_en && bus.i_app_rdy;
    wren         = (state_q == ST_WRITE) && data_pending && bus.i_wdata_valid;
    wfire        = wren && bus.i_app_wdf_rdy;
    rd_issue     = cmd_fire && (state_q == ST_READ);
    rd_ret       = bus.i_app_rd_data_valid;

    state_d    = state_q;
    beats_d    = beats_q;
    cmd_cnt_d  = cmd_cnt_q;
    data_cnt_d = data_cnt_q;
    ret_cnt_d  = ret_cnt_q;
    out_cnt_d  = out_cnt_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    rd_data_d  = bus.i_app_rd_data;
    rd_valid_d = rd_ret;

    if (cmd_fire) begin
      cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
      addr_d    = addr_q + ADDR_WIDTH'(ADDR_STEP);
    end
    if (wfire) begin
      data_cnt_d = data_cnt_q + CNT_W'(1);
    end
    if ((state_q == ST_READ) && rd_ret) begin
      ret_cnt_d = ret_cnt_q + CNT_W'(1);
    end
    // Stray returns with nothing outstanding must not wrap the counter
    if (rd_issue && !rd_ret) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (!rd_issue && rd_ret && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - OUT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid && req_ready) begin
          state_d    = bus.i_req_rw ? ST_WRITE : ST_READ;
          beats_d    = CNT_W'(bus.i_req_len) + CNT_W'(1);
          cmd_cnt_d  = '0;
          data_cnt_d = '0;
          ret_cnt_d  = '0;
          addr_d     = bus.i_req_addr;
          cmd_d      = bus.i_req_rw ? 3'b000 : 3'b001;
        end
      end
      ST_WRITE: begin
        if ((cmd_cnt_q == beats_q) && (data_cnt_q == beats_q)) state_d = ST_DONE;
      end
      ST_READ: begin
        if ((cmd_cnt_q == beats_q) && (ret_cnt_q == beats_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
    if (mcu_sys_rst) begin
      state_q    <= ST_IDLE;
      beats_q    <= '0;
      cmd_cnt_q  <= '0;
      data_cnt_q <= '0;
      ret_cnt_q  <= '0;
      out_cnt_q  <= '0;
      addr_q     <= '0;
      cmd_q      <= 3'b001;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      cmd_cnt_q  <= cmd_cnt_d;
      data_cnt_q <= data_cnt_d;
      ret_cnt_q  <= ret_cnt_d;
      out_cnt_q  <= out_cnt_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.o_req_ready    = req_ready;
  assign bus.o_wdata_ready  = (state_q == ST_WRITE) && data_pending && bus.i_app_wdf_rdy;
  assign bus.o_rd_data      = rd_data_q;
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_done         = (state_q == ST_DONE);
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_app_addr     = addr_q;
  assign bus.o_app_cmd      = cmd_q;
  assign bus.o_app_en       = app_en;
  assign bus.o_app_wdf_data = bus.i_wdata;
  assign bus.o_app_wdf_mask = bus.i_wmask;
  assign bus.o_app_wdf_wren = wren;
  assign bus.o_app_wdf_end  = wren;
endmodule

// File: doc/ddr_app_sequencer.md
Name: ddr_app_sequencer

Overview:
Parametrised request sequencer between the MCU and the MIG 7-series application (app_*) interface.
- Accepts one user request at a time: read or write, start address, 1..MAX_BURST_BEATS beats.
- Breaks each request into per-beat MIG commands and drives app_en/app_cmd/app_addr and the write-data path, honouring app_rdy/app_wdf_rdy backpressure.
- Returns read data with a bounded outstanding-read count and signals completion.
- Sits in the ui_clk domain, directly beside mig_7series_0.

Parameters:
ADDR_WIDTH, 28, app_addr width.
DATA_WIDTH, 128, app data width (one beat).
MAX_BURST_BEATS, 16, maximum beats per request (power of 2).
ADDR_STEP, 8, app_addr increment per beat.
MAX_OUTSTANDING, 8, maximum read commands accepted but not yet returned.

Ports:
clk_166M66  in  1  MIG ui_clk; all logic on its rising edge.
mcu_sys_rst  in  1  asynchronous, active-high reset.
i_init_calib_complete  in  1  MIG calibration done.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when valid&ready.
i_req_rw  in  1  1 = write, 0 = read.
i_req_addr  in  ADDR_WIDTH  first beat address.
i_req_len  in  clog2(MAX_BURST_BEATS)  beats minus 1.
i_wdata  in  DATA_WIDTH  write beat data.
i_wmask  in  DATA_WIDTH/8  write byte mask (1 = masked).
i_wdata_valid  in  1  write beat valid.
o_wdata_ready  out  1  write beat consumed when valid&ready.
o_rd_data  out  DATA_WIDTH  read beat.
o_rd_valid  out  1  read beat valid, one cycle.
o_done  out  1  one-cycle pulse, request complete.
o_busy  out  1  state != IDLE.
o_app_addr  out  ADDR_WIDTH  to app_addr.
o_app_cmd  out  3  000 write, 001 read.
o_app_en  out  1  to app_en.
i_app_rdy  in  1  from app_rdy.
o_app_wdf_data  out  DATA_WIDTH  to app_wdf_data.
o_app_wdf_mask  out  DATA_WIDTH/8  to app_wdf_mask.
o_app_wdf_wren  out  1  to app_wdf_wren.
o_app_wdf_end  out  1  to app_wdf_end.
i_app_wdf_rdy  in  1  from app_wdf_rdy.
i_app_rd_data  in  DATA_WIDTH  from app_rd_data.
i_app_rd_data_valid  in  1  from app_rd_data_valid.

Behaviour:
- Reset (async assert, sync release): state IDLE, all counters 0. Every output is 0 except o_app_cmd, which resets to 3'b001.
- States:
  - IDLE -> WRITE or READ on i_req_valid & o_req_ready.
  - WRITE -> DONE when cmd_cnt and data_cnt both equal beats.
  - READ -> DONE when cmd_cnt and ret_cnt both equal beats.
  - DONE -> IDLE after one cycle; o_done = 1 in DONE.
- o_req_ready = (state == IDLE) & i_init_calib_complete. On accept, latch rw, addr and beats = i_req_len + 1.
- Commands:
  - o_app_en = 1 in WRITE/READ while cmd_cnt < beats. In READ it additionally requires outstanding < MAX_OUTSTANDING.
  - A command is accepted on o_app_en & i_app_rdy. On accept: cmd_cnt++ and o_app_addr += ADDR_STEP (modulo 2^ADDR_WIDTH; wrap is legal, no error).
  - o_app_addr, o_app_cmd and o_app_en hold stable while i_app_rdy = 0.
- Write data:
  - Path is combinational. o_app_wdf_wren = o_app_wdf_end = (state == WRITE) & (data_cnt < beats) & i_wdata_valid.
  - o_wdata_ready = (state == WRITE) & (data_cnt < beats) & i_app_wdf_rdy.
  - data_cnt++ on wren & i_app_wdf_rdy. o_app_wdf_data/o_app_wdf_mask pass i_wdata/i_wmask through.
  - Data may lead or lag commands freely; the two counters are independent.
- Reads:
  - outstanding increments on read-command accept and decrements on i_app_rd_data_valid. Both in one cycle: unchanged.
  - o_rd_data/o_rd_valid are registered copies of i_app_rd_data/i_app_rd_data_valid (1-cycle latency). ret_cnt++ per return.
  - Returns arriving in IDLE are forwarded but not counted (cannot occur in correct use).
- i_init_calib_complete falling mid-request does not abort the request; it only blocks new accepts.
- Reset mid-request drops all state immediately. Partially issued MIG commands are the system's responsibility.
- Request accepted while data is held: i_wdata_valid is ignored until state == WRITE.

Test Plan:
- Reset, then calib=0 with req_valid=1 -> o_req_ready=0, o_app_en=0. Raise calib -> accepted next cycle, o_busy=1.
- Write, addr=0x100, len=3, app_rdy and app_wdf_rdy always 1, wdata valid -> 4 commands at 0x100/0x108/0x110/0x118 cmd=000, 4 wren beats, o_done one cycle later, then IDLE.
- Write, len=1, app_rdy low 5 cycles -> app_addr/app_en held stable throughout. Data beats complete first; o_done only after the 2nd command is accepted.
- Read, len=15, MAX_OUTSTANDING=8, returns delayed 20 cycles -> app_en drops after 8 accepts. Issue resumes one return later. 16 o_rd_valid pulses, each 1 cycle after app_rd_data_valid. o_done after the 16th.
- Read at addr=0xFFFFFF8 (28 bits), len=1 -> second command address is 0x0000000.
- Assert mcu_sys_rst during WRITE beat 2 -> all outputs 0 (app_cmd 001) asynchronously. After release, state IDLE with counters 0, and a new request completes normally.
